// File: rtl/stlb_miss_sched_pkg.sv
// stlb_miss_sched_pkg: widths and scheduler state encoding shared by the
// shared-TLB miss scheduler and its arbiter.
package stlb_miss_sched_pkg;
    localparam int unsigned VLEN       = 39;
    localparam int unsigned ASID_WIDTH = 16;
    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, PTW_REQ, PTW_WAIT, DRAIN} sched_state_e;
endpackage

// File: rtl/stlb_miss_sched_arb.sv
// stlb_miss_sched_arb: fixed DTLB-priority arbiter with a starvation counter
// that forces an ITLB grant after MaxDtlbWins DTLB grants while the ITLB waits.
module stlb_miss_sched_arb #(
    parameter int unsigned MaxDtlbWins = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    input  logic       flush_i,
    output logic [1:0] gnt_o
);
    localparam int unsigned CW = $clog2(MaxDtlbWins + 1);
    logic [CW-1:0] cnt_q;
    logic          itlb_win;
    // req_i/gnt_o bit 1 is the ITLB, bit 0 the DTLB
    assign itlb_win = req_i[1] && (!req_i[0] || cnt_q == CW'(MaxDtlbWins));
    assign gnt_o    = {itlb_win, req_i[0] && !itlb_win};
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (flush_i || (grant_en_i && gnt_o[1])) begin
            cnt_q <= '0;
        end else if (grant_en_i && gnt_o[0] && req_i[1]) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/stlb_miss_sched.sv
// stlb_miss_sched: sequences ITLB/DTLB misses through the shared TLB and,
// on a shared-TLB miss, through the page-table walker, then fills and completes.
module stlb_miss_sched
    import stlb_miss_sched_pkg::*;
#(
    parameter int unsigned MaxDtlbWins = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  itlb_miss_i,
    input  logic [VLEN-1:0]       itlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0] itlb_asid_i,
    input  logic                  dtlb_miss_i,
    input  logic [VLEN-1:0]       dtlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
    output logic                  stlb_req_o,
    output logic [VLEN-1:0]       stlb_vaddr_o,
    output logic [ASID_WIDTH-1:0] stlb_asid_o,
    output logic                  stlb_is_instr_o,
    input  logic                  stlb_hit_i,
    output logic                  stlb_fill_o,
    output logic                  ptw_req_o,
    input  logic                  ptw_ready_i,
    input  logic                  ptw_valid_i,
    input  logic                  ptw_error_i,
    output logic                  itlb_done_o,
    output logic                  dtlb_done_o,
    output logic                  fault_o,
    output logic                  busy_o
);
    sched_state_e          state_q;
    logic [VLEN-1:0]       vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  is_instr_q, itlb_done_q, dtlb_done_q, fill_q, fault_q;
    logic [1:0]            gnt;
    logic                  grant_en;
    assign grant_en = (state_q == IDLE) && !flush_i;
    stlb_miss_sched_arb #(.MaxDtlbWins(MaxDtlbWins)) u_arb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      ({itlb_miss_i, dtlb_miss_i}),
        .grant_en_i (grant_en),
        .flush_i    (flush_i),
        .gnt_o      (gnt)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vaddr_q     <= '0;
            asid_q      <= '0;
            is_instr_q  <= 1'b0;
            itlb_done_q <= 1'b0;
            dtlb_done_q <= 1'b0;
            fill_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            itlb_done_q <= 1'b0;
            dtlb_done_q <= 1'b0;
            fill_q      <= 1'b0;
            fault_q     <= 1'b0;
            case (state_q)
                IDLE: if (grant_en && |gnt) begin
                    state_q    <= LOOKUP;
                    vaddr_q    <= gnt[1] ? itlb_vaddr_i : dtlb_vaddr_i;
                    asid_q     <= gnt[1] ? itlb_asid_i : dtlb_asid_i;
                    is_instr_q <= gnt[1];
                end
                LOOKUP: state_q <= flush_i ? IDLE : CHECK;
                CHECK: if (flush_i) begin
                    state_q <= IDLE;
                end else if (stlb_hit_i) begin
                    state_q     <= IDLE;
                    itlb_done_q <= is_instr_q;
                    dtlb_done_q <= !is_instr_q;
                end else begin
                    state_q <= PTW_REQ;
                end
                PTW_REQ: if (flush_i) state_q <= IDLE;
                         else if (ptw_ready_i) state_q <= PTW_WAIT;
                // a flush racing the walk response simply drops it; otherwise drain it
                PTW_WAIT: if (flush_i) begin
                    state_q <= ptw_valid_i ? IDLE : DRAIN;
                end else if (ptw_valid_i) begin
                    state_q     <= IDLE;
                    itlb_done_q <= is_instr_q;
                    dtlb_done_q <= !is_instr_q;
                    fill_q      <= !ptw_error_i;
                    fault_q     <= ptw_error_i;
                end
                DRAIN: if (ptw_valid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign stlb_req_o      = state_q == LOOKUP;
    assign ptw_req_o       = (state_q == PTW_REQ) && !flush_i;
    assign busy_o          = state_q != IDLE;
    assign stlb_vaddr_o    = vaddr_q;
    assign stlb_asid_o     = asid_q;
    assign stlb_is_instr_o = is_instr_q;
    assign stlb_fill_o     = fill_q;
    assign itlb_done_o     = itlb_done_q;
    assign dtlb_done_o     = dtlb_done_q;
    assign fault_o         = fault_q;
endmodule
